// File: rtl/fw_log_capture_mc.sv
// Multi-channel firmware-log capture: snoops SRAM write ports for log-address
// hits, tags them with channel and timestamp, and queues them on a stream.
module fw_log_capture_mc #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 16,
   parameter int CNT_WIDTH  = 8,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mon_en,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] target_addr,
   input  logic [NUM_CH-1:0]            ch_ceb,
   input  logic [NUM_CH-1:0]            ch_web,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
   output logic                         log_valid,
   input  logic                         log_ready,
   output logic [CH_W-1:0]              log_ch,
   output logic [TS_WIDTH-1:0]          log_ts,
   output logic [DATA_WIDTH-1:0]        log_data,
   output logic [LVL_W-1:0]             fifo_level,
   input  logic                         drop_clr,
   output logic [NUM_CH*CNT_WIDTH-1:0]  drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = CH_W + TS_WIDTH + DATA_WIDTH;

   logic [TS_WIDTH-1:0]   ts_q;
   logic [NUM_CH-1:0]     hit;
   logic [NUM_CH-1:0]     gnt;
   logic [NUM_CH-1:0]     drop;
   logic [NUM_CH-1:0]     pv_q, pv_d;
   logic [TS_WIDTH-1:0]   pts_q [NUM_CH];
   logic [TS_WIDTH-1:0]   pts_d [NUM_CH];
   logic [DATA_WIDTH-1:0] pd_q  [NUM_CH];
   logic [DATA_WIDTH-1:0] pd_d  [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
   logic [CH_W-1:0]       rr_q, rr_d;
   logic [CH_W-1:0]       gnt_ch;
   logic                  gnt_any;
   logic [CH_W:0]         k;
   logic [PTR_W-1:0]      wr_q, rd_q;
   logic [LVL_W-1:0]      lvl_q, lvl_d;
   logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]      push_ent;
   logic [ENT_W-1:0]      head;
   logic                  full;
   logic                  pop;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = mon_en & ~ch_ceb[i] & ~ch_web[i] &
                  (ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                   target_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      end
   end

   assign log_valid = (lvl_q != '0);
   assign pop       = log_valid & log_ready;
   assign full      = (lvl_q == LVL_W'(FIFO_DEPTH));

   // Round-robin search from rr_q; a pop this cycle frees a full FIFO slot.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_ch  = '0;
      k       = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         k = {1'b0, rr_q} + (CH_W+1)'(j);
         if (k >= (CH_W+1)'(NUM_CH)) begin
            k = k - (CH_W+1)'(NUM_CH);
         end
         if (!gnt_any && pv_q[k[CH_W-1:0]] && (!full || pop)) begin
            gnt_any              = 1'b1;
            gnt[k[CH_W-1:0]]     = 1'b1;
            gnt_ch               = k[CH_W-1:0];
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_any) begin
         if (gnt_ch == CH_W'(NUM_CH - 1)) begin
            rr_d = '0;
         end else begin
            rr_d = gnt_ch + CH_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pv_d[i]  = pv_q[i];
         pts_d[i] = pts_q[i];
         pd_d[i]  = pd_q[i];
         drop[i]  = 1'b0;
         if (hit[i] && (!pv_q[i] || gnt[i])) begin
            pv_d[i]  = 1'b1;
            pts_d[i] = ts_q;
            pd_d[i]  = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            if (gnt[i]) begin
               pv_d[i] = 1'b0;
            end
            if (hit[i]) begin
               drop[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (drop_clr) begin
            cnt_d[i] = CNT_WIDTH'(drop[i]);
         end else if (drop[i] && !(&cnt_q[i])) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      lvl_d = lvl_q;
      unique case ({gnt_any, pop})
         2'b10:   lvl_d = lvl_q + LVL_W'(1);
         2'b01:   lvl_d = lvl_q - LVL_W'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   assign push_ent = {gnt_ch, pts_q[gnt_ch], pd_q[gnt_ch]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q  <= '0;
         pv_q  <= '0;
         rr_q  <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pts_q[i] <= '0;
            pd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         ts_q  <= ts_q + TS_WIDTH'(1);
         pv_q  <= pv_d;
         rr_q  <= rr_d;
         lvl_q <= lvl_d;
         if (gnt_any) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            pts_q[i] <= pts_d[i];
            pd_q[i]  <= pd_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset: nothing reads it while the level is zero.
   always_ff @(posedge clk) begin
      if (gnt_any) begin
         mem_q[wr_q] <= push_ent;
      end
   end

   assign head       = mem_q[rd_q];
   assign log_ch     = log_valid ? head[ENT_W-1 -: CH_W] : '0;
   assign log_ts     = log_valid ? head[DATA_WIDTH +: TS_WIDTH] : '0;
   assign log_data   = log_valid ? head[DATA_WIDTH-1:0] : '0;
   assign fifo_level = lvl_q;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_fw_log_capture_mc.sv
// Bench for fw_log_capture_mc: directed tables and sequences plus random
// traffic checked against a queue-based reference model.
module tb_fw_log_capture_mc;

   localparam int NCH = 4;
   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int DEP = 16;
   localparam int CW  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mon_en;
   logic [NCH*AW-1:0] target_addr;
   logic [NCH-1:0]    ch_ceb;
   logic [NCH-1:0]    ch_web;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic              log_valid;
   logic              log_ready;
   logic [1:0]        log_ch;
   logic [15:0]       log_ts;
   logic [31:0]       log_data;
   logic [4:0]        fifo_level;
   logic              drop_clr;
   logic [NCH*CW-1:0] drop_cnt;

   fw_log_capture_mc dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mon_en      (mon_en),
      .target_addr (target_addr),
      .ch_ceb      (ch_ceb),
      .ch_web      (ch_web),
      .ch_addr     (ch_addr),
      .ch_wdata    (ch_wdata),
      .log_valid   (log_valid),
      .log_ready   (log_ready),
      .log_ch      (log_ch),
      .log_ts      (log_ts),
      .log_data    (log_data),
      .fifo_level  (fifo_level),
      .drop_clr    (drop_clr),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      int          ts;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          mts;
   bit          pv [NCH];
   int          pts[NCH];
   logic [31:0] pd [NCH];
   int          rr;
   int          dc [NCH];
   int          vec = 0;
   int          bad = 0;

   function automatic logic [AW-1:0] tgt(input int i);
      logic [AW-1:0] t;
      t = 14'h0100;
      t = t + AW'(i * 16);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      vec++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      mts = 0;
      rr  = 0;
      for (int i = 0; i < NCH; i++) begin
         pv[i] = 0;
         dc[i] = 0;
      end
   endtask

   // One clock of the reference: pop, grant, capture, count drops.
   task automatic m_step();
      bit pop;
      bit can;
      bit h;
      int g;
      int s;
      pop = (mq.size() > 0) && (log_ready === 1'b1);
      can = (mq.size() < DEP) || pop;
      g   = -1;
      if (can) begin
         for (int j = 0; j < NCH; j++) begin
            s = (rr + j) % NCH;
            if (g < 0 && pv[s]) g = s;
         end
      end
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
         mq.push_back('{g, pts[g], pd[g]});
         pv[g] = 0;
         rr    = (g + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++) begin
         bit dr;
         dr = 0;
         h  = mon_en && !ch_ceb[i] && !ch_web[i] &&
              (ch_addr[i*AW +: AW] == tgt(i));
         if (h) begin
            if (!pv[i]) begin
               pv[i]  = 1;
               pts[i] = mts;
               pd[i]  = ch_wdata[i*DW +: DW];
            end else begin
               dr = 1;
            end
         end
         if (drop_clr) dc[i] = dr ? 1 : 0;
         else if (dr && dc[i] < 255) dc[i]++;
      end
      mts = (mts + 1) % 65536;
   endtask

   task automatic check_all();
      chk("valid", log_valid, mq.size() != 0);
      chk("level", fifo_level, mq.size());
      if (mq.size() != 0) begin
         chk("head_ch", log_ch, mq[0].ch);
         chk("head_ts", log_ts, mq[0].ts);
         chk("head_data", log_data, mq[0].d);
      end
      for (int i = 0; i < NCH; i++) begin
         chk("drop_cnt", drop_cnt[i*CW +: CW], dc[i]);
      end
   endtask

   task automatic cyc();
      m_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      ch_ceb = '1;
      ch_web = '1;
      ch_addr = '0;
      ch_wdata = '0;
   endtask

   task automatic hit_on(input int i, input logic [31:0] d);
      ch_ceb[i] = 1'b0;
      ch_web[i] = 1'b0;
      ch_addr[i*AW +: AW] = tgt(i);
      ch_wdata[i*DW +: DW] = d;
   endtask

   task automatic drain();
      int n;
      n = 0;
      log_ready = 1'b1;
      while (n < 64 && (mq.size() != 0 || pv[0] || pv[1] || pv[2] || pv[3])) begin
         cyc();
         n++;
      end
      chk("drain_done", mq.size(), 0);
      log_ready = 1'b0;
   endtask

   task automatic burst(input int first);
      for (int i = 0; i < NCH; i++) hit_on(i, 32'hB000 + i);
      cyc();
      idle();
      log_ready = 1'b1;
      cyc();
      for (int k = 0; k < NCH; k++) begin
         chk("t3_valid", log_valid, 1);
         chk("t3_order", log_ch, (first + k) % NCH);
         cyc();
      end
      log_ready = 1'b0;
   endtask

   typedef struct {
      logic en;
      logic ceb;
      logic web;
      int   da;
      int   lvl;
   } t2_t;

   t2_t tv[5];

   initial begin
      int n;
      int last;
      bit mono;
      tv[0] = '{1'b1, 1'b1, 1'b0, 0, 0};
      tv[1] = '{1'b1, 1'b0, 1'b1, 0, 0};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1, 0};
      tv[3] = '{1'b0, 1'b0, 1'b0, 0, 0};
      tv[4] = '{1'b1, 1'b0, 1'b0, 0, 1};

      rst_n = 1'b0;
      mon_en = 1'b1;
      log_ready = 1'b0;
      drop_clr = 1'b0;
      idle();
      for (int i = 0; i < NCH; i++) target_addr[i*AW +: AW] = tgt(i);
      repeat (2) @(negedge clk);
      chk("rst_valid", log_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ch", log_ch, 0);
      chk("rst_ts", log_ts, 0);
      chk("rst_data", log_data, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      m_reset();

      // single hit at ts=5
      while (mts != 5) cyc();
      hit_on(0, 32'hDEADBEEF);
      cyc();
      idle();
      cyc();
      chk("t1_valid", log_valid, 1);
      chk("t1_ch", log_ch, 0);
      chk("t1_ts", log_ts, 5);
      chk("t1_data", log_data, 32'hDEADBEEF);
      log_ready = 1'b1;
      cyc();
      log_ready = 1'b0;
      chk("t1_level", fifo_level, 0);

      // filter table on ch2
      for (int r = 0; r < 5; r++) begin
         mon_en = tv[r].en;
         ch_ceb[2] = tv[r].ceb;
         ch_web[2] = tv[r].web;
         ch_addr[2*AW +: AW] = tgt(2) + AW'(tv[r].da);
         ch_wdata[2*DW +: DW] = 32'h2000 + r;
         cyc();
         idle();
         mon_en = 1'b1;
         cyc();
         chk("t2_level", fifo_level, tv[r].lvl);
         chk("t2_drops", drop_cnt, 0);
         drain();
      end

      // fairness
      hit_on(3, 32'h3333);
      cyc();
      idle();
      drain();
      burst(0);
      burst(0);
      hit_on(2, 32'h2222);
      cyc();
      idle();
      drain();
      burst(3);

      // overflow
      log_ready = 1'b0;
      for (int c = 0; c < 18; c++) begin
         hit_on(1, 32'h4000 + c);
         cyc();
      end
      idle();
      chk("t4_level", fifo_level, 16);
      for (int i = 0; i < NCH; i++) begin
         chk("t4_drop", drop_cnt[i*CW +: CW], (i == 1) ? 1 : 0);
      end
      log_ready = 1'b1;
      n = 0;
      last = -1;
      mono = 1;
      for (int c = 0; c < 40; c++) begin
         if (log_valid) begin
            if (int'(log_ts) <= last) mono = 0;
            last = int'(log_ts);
            n++;
         end
         cyc();
      end
      log_ready = 1'b0;
      chk("t4_count", n, 17);
      chk("t4_ts_incr", mono, 1);

      // saturation and clear
      for (int c = 0; c < 317; c++) begin
         hit_on(3, 32'h5000 + c);
         cyc();
      end
      idle();
      chk("t5_sat", drop_cnt[3*CW +: CW], 255);
      drop_clr = 1'b1;
      cyc();
      chk("t5_clr", drop_cnt[3*CW +: CW], 0);
      hit_on(3, 32'h5555);
      cyc();
      chk("t5_clr_drop", drop_cnt[3*CW +: CW], 1);
      drop_clr = 1'b0;
      idle();

      // reset mid-drain
      log_ready = 1'b1;
      for (int c = 0; c < 40 && mq.size() != 10; c++) cyc();
      log_ready = 1'b0;
      chk("t6_pre_level", fifo_level, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", log_valid, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_drop", drop_cnt, 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      hit_on(0, 32'h6006);
      cyc();
      idle();
      cyc();
      chk("t6_valid2", log_valid, 1);
      chk("t6_ts", log_ts, 0);
      drain();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         mon_en = ($urandom % 8) != 0;
         for (int i = 0; i < NCH; i++) begin
            ch_ceb[i] = ($urandom % 3) == 0;
            ch_web[i] = ($urandom % 4) == 0;
            ch_addr[i*AW +: AW] = (($urandom % 5) == 0) ? tgt(i) + AW'(1) : tgt(i);
            ch_wdata[i*DW +: DW] = $urandom;
         end
         if (c < 1000) log_ready = ($urandom % 4) != 0;
         else if (c < 2000) log_ready = ($urandom % 4) == 0;
         else log_ready = ($urandom % 2) == 0;
         drop_clr = ($urandom % 64) == 0;
         cyc();
      end
      idle();
      drop_clr = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
